memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_memory_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
//
// Round-robin request/grant arbiter that shares the single-ported memory_unit
// between NUM_CH requesters (traversal unit, execute module, allocator/GC).
// One transaction runs at a time. A channel is granted, and its func, address
// and write data are latched. mem_execute is pulsed once. The arbiter waits
// for is_ready (mem_ready) to fall and rise again. It then returns read data
// with a one-cycle done pulse to the owner.
//
// Optional feature: define ARB_LOCK_EN to enable req_lock. A channel that
// completes with req_lock set keeps the grant, so it can run multi-access
// atomic sequences. When ARB_LOCK_EN is undefined, req_lock is ignored and no
// lock logic is built.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   req            in   [NUM_CH]        per-channel request, held until done
//   req_func       in   [2*NUM_CH]      memory func, channel i at [2i+1:2i]
//   req_address    in   [ADDR_W*NUM_CH] address per channel
//   req_write_data in   [DATA_W*NUM_CH] write data per channel
//   req_lock       in   [NUM_CH]        keep grant after completion
//   grant          out  [NUM_CH]        one-hot owner of the memory port
//   done           out  [NUM_CH]        one-cycle completion pulse to owner
//   rd_data        out  [DATA_W]        read_data captured at completion
//   mem_func       out  [2]             to memory_unit
//   mem_execute    out                  to memory_unit, one-cycle pulse
//   mem_address    out  [ADDR_W]        to memory_unit
//   mem_write_data out  [DATA_W]        to memory_unit
//   mem_ready      in                   memory_unit is_ready
//   read_data      in   [DATA_W]        memory_unit read_data
// ----------------------------------------------------------------------------
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

module memory_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
    parameter int DATA_W = `MEMORY_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [2*NUM_CH-1:0]      req_func,
    input  logic [ADDR_W*NUM_CH-1:0] req_address,
    input  logic [DATA_W*NUM_CH-1:0] req_write_data,
    input  logic [NUM_CH-1:0]        req_lock,
    output logic [NUM_CH-1:0]        grant,
    output logic [NUM_CH-1:0]        done,
    output logic [DATA_W-1:0]        rd_data,
    output logic [1:0]               mem_func,
    output logic                     mem_execute,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_write_data,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        read_data
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0]   LAST_RST = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                exec_q, exec_d;
    logic [1:0]          func_q, func_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    // Set once BUSY has either seen mem_ready low or spent one full cycle
    // with it high. The next mem_ready=1 sample then completes the access.
    logic                armed_q, armed_d;

`ifdef ARB_LOCK_EN
    logic                locked_q, locked_d;
`else
    logic                unused_req_lock;
    assign unused_req_lock = ^req_lock;
`endif

    // Per-channel request fields, split out of the flat buses.
    logic [1:0]          ch_func  [NUM_CH];
    logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
    logic [DATA_W-1:0]   ch_wdata [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_func[gi]  = req_func[2*gi +: 2];
        assign ch_addr[gi]  = req_address[ADDR_W*gi +: ADDR_W];
        assign ch_wdata[gi] = req_write_data[DATA_W*gi +: DATA_W];
    end

    // Round-robin pick: search last+1, last+2, ... (mod NUM_CH). The loop runs
    // from the farthest candidate to the nearest, so the nearest requester
    // wins.
    logic                pick_valid;
    logic [CH_W-1:0]     pick_ch;
    int                  rr_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_ch    = '0;
        rr_idx     = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            rr_idx = int'(last_q) + k;
            if (rr_idx >= NUM_CH) begin
                rr_idx = rr_idx - NUM_CH;
            end
            if (req[CH_W'(rr_idx)]) begin
                pick_valid = 1'b1;
                pick_ch    = CH_W'(rr_idx);
            end
        end
    end

    logic                start;
    logic [CH_W-1:0]     start_ch;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        rd_data_d = rd_data_q;
        exec_d    = 1'b0;
        func_d    = func_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
        ch_d      = ch_q;
        armed_d   = armed_q;
`ifdef ARB_LOCK_EN
        locked_d  = locked_q;
`endif
        start     = 1'b0;
        start_ch  = pick_ch;

        case (state_q)
            IDLE: begin
`ifdef ARB_LOCK_EN
                // While locked, only the owner may start. The owner gives up
                // the lock by dropping both req and req_lock.
                if (locked_q) begin
                    start_ch = ch_q;
                    if (req[ch_q] && mem_ready) begin
                        start = 1'b1;
                    end else if (!req[ch_q] && !req_lock[ch_q]) begin
                        locked_d = 1'b0;
                        grant_d  = '0;
                    end
                end else
`endif
                if (mem_ready && pick_valid) begin
                    start = 1'b1;
                end

                if (start) begin
                    state_d = ISSUE;
                    ch_d    = start_ch;
                    grant_d = ONE_HOT0 << start_ch;
                    func_d  = ch_func[start_ch];
                    addr_d  = ch_addr[start_ch];
                    wdata_d = ch_wdata[start_ch];
                    armed_d = 1'b0;
                end
            end

            ISSUE: begin
                exec_d  = 1'b1;
                armed_d = 1'b0;
                state_d = BUSY;
            end

            BUSY: begin
                if (!mem_ready) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    rd_data_d = read_data;
                    done_d    = grant_q;
                    state_d   = DONE;
                end else begin
                    armed_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                last_d  = ch_q;
                func_d  = '0;
                addr_d  = '0;
                wdata_d = '0;
`ifdef ARB_LOCK_EN
                if (req_lock[ch_q]) begin
                    locked_d = 1'b1;
                end else begin
                    grant_d = '0;
                end
`else
                grant_d = '0;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            rd_data_q <= '0;
            exec_q    <= 1'b0;
            func_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            last_q    <= LAST_RST;
            ch_q      <= '0;
            armed_q   <= 1'b0;
`ifdef ARB_LOCK_EN
            locked_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            exec_q    <= exec_d;
            func_q    <= func_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
            ch_q      <= ch_d;
            armed_q   <= armed_d;
`ifdef ARB_LOCK_EN
            locked_q  <= locked_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign rd_data        = rd_data_q;
    assign mem_execute    = exec_q;
    assign mem_func       = func_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter with NUM_CH=3, in front of a small
// behavioural memory_unit. The memory drops is_ready for `lat` cycles after
// each execute. Each directed step pushes its expected transactions
// (channel, fields, read data) into a scoreboard queue. A monitor checks every
// mem_execute and done pulse against the front of that queue.
// Lock expectations follow ARB_LOCK_EN.
// ----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_CH-1:0]        req = '0;
    logic [2*NUM_CH-1:0]      req_func = '0;
    logic [ADDR_W*NUM_CH-1:0] req_address = '0;
    logic [DATA_W*NUM_CH-1:0] req_write_data = '0;
    logic [NUM_CH-1:0]        req_lock = '0;
    logic [NUM_CH-1:0]        grant;
    logic [NUM_CH-1:0]        done;
    logic [DATA_W-1:0]        rd_data;
    logic [1:0]               mem_func;
    logic                     mem_execute;
    logic [ADDR_W-1:0]        mem_address;
    logic [DATA_W-1:0]        mem_write_data;
    logic                     mem_ready = 1'b1;
    logic [DATA_W-1:0]        read_data = '0;

    always #5 clk = ~clk;

    memory_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_func       (req_func),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .req_lock       (req_lock),
        .grant          (grant),
        .done           (done),
        .rd_data        (rd_data),
        .mem_func       (mem_func),
        .mem_execute    (mem_execute),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_ready      (mem_ready),
        .read_data      (read_data)
    );

    // ---------------- behavioural memory_unit ----------------
    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] rdata_pend = '0;
    int                lat = 1;
    int                busy_cnt = 0;

    always @(posedge clk) begin
        if (mem_execute) begin
            mem_ready  <= 1'b0;
            busy_cnt   <= lat;
            rdata_pend <= mem[mem_address[5:0]];
        end else if (!mem_ready) begin
            if (busy_cnt <= 1) begin
                mem_ready <= 1'b1;
                read_data <= rdata_pend;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] mem_val(input int a);
        if (a == 5) return 32'h0000_002A;
        return 32'hA500_0000 + 32'(a * 7);
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int                ch;
        logic [1:0]        func;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t sb[$];

    task automatic expect_tx(input int ch, input logic [1:0] f, input int a);
        exp_t e;
        e.ch    = ch;
        e.func  = f;
        e.addr  = ADDR_W'(a);
        e.wdata = 32'hC0DE_0000 + 32'(a);
        e.rdata = mem_val(a);
        sb.push_back(e);
    endtask

    task automatic set_ch(input int ch, input logic [1:0] f, input int a);
        logic [2*NUM_CH-1:0]      fv;
        logic [ADDR_W*NUM_CH-1:0] av;
        logic [DATA_W*NUM_CH-1:0] dv;
        logic [2*NUM_CH-1:0]      fm;
        logic [ADDR_W*NUM_CH-1:0] am;
        logic [DATA_W*NUM_CH-1:0] dm;
        fv = '0; av = '0; dv = '0; fm = '0; am = '0; dm = '0;
        fv[1:0]        = f;
        av[ADDR_W-1:0] = ADDR_W'(a);
        dv[DATA_W-1:0] = 32'hC0DE_0000 + 32'(a);
        fm[1:0]        = '1;
        am[ADDR_W-1:0] = '1;
        dm[DATA_W-1:0] = '1;
        req_func       = (req_func & ~(fm << (2 * ch))) | (fv << (2 * ch));
        req_address    = (req_address & ~(am << (ADDR_W * ch))) | (av << (ADDR_W * ch));
        req_write_data = (req_write_data & ~(dm << (DATA_W * ch))) | (dv << (DATA_W * ch));
    endtask

    function automatic bit is_done(input int ch);
        return (done & (NUM_CH'(1) << ch)) != '0;
    endfunction

    task automatic wait_done(input int ch, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (is_done(ch)) return;
        end
        check(tag, 64'(is_done(ch)), 64'(1));
    endtask

    task automatic wait_exec(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_execute === 1'b1) return;
        end
        check(tag, 64'(mem_execute), 64'(1));
    endtask

    // ---------------- monitor ----------------
    int                mon_cyc = 0;
    int                mon_rise = -10;
    int                mon_exec = 0;
    logic              mon_prev_ready = 1'b1;
    logic [NUM_CH-1:0] mon_prev_grant = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (mem_ready && !mon_prev_ready) mon_rise = mon_cyc;
            mon_prev_ready = mem_ready;
            if (!rst) begin
                mon_exec       = 0;
                mon_prev_grant = '0;
            end else begin
                check("grant_onehot0", 64'($onehot0(grant)), 64'(1));
                check("dead_cycle", 64'(mon_prev_grant != '0 && grant != '0 && grant != mon_prev_grant), 64'(0));
                mon_prev_grant = grant;
                if (grant == '0)
                    check("idle_fields_zero", 64'({mem_func, mem_address, mem_write_data}), 64'(0));
                if (mem_execute) begin
                    mon_exec++;
                    if (sb.size() == 0) begin
                        check("exec_unexpected", 64'(mem_execute), 64'(0));
                    end else begin
                        check("exec_grant", 64'(grant), 64'(1) << sb[0].ch);
                        check("exec_func", 64'(mem_func), 64'(sb[0].func));
                        check("exec_addr", 64'(mem_address), 64'(sb[0].addr));
                        check("exec_wdata", 64'(mem_write_data), 64'(sb[0].wdata));
                    end
                end
                if (done != '0) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", 64'(done), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("done_vec", 64'(done), 64'(1) << e.ch);
                        check("done_rd_data", 64'(rd_data), 64'(e.rdata));
                        check("done_exec_once", 64'(mon_exec), 64'(1));
                        check("done_latency", 64'(mon_cyc), 64'(mon_rise + 1));
                        $display("tx ch=%0d addr=%0d rd_data=0x%0h done=%b", e.ch, e.addr, rd_data, done);
                    end
                    mon_exec = 0;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n, n0, n1;
        bit unlock;

        for (int i = 0; i < 64; i++) mem[i] = mem_val(i);

        // Reset values
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_mem_execute", 64'(mem_execute), 64'(0));
        check("rst_mem_func", 64'(mem_func), 64'(0));
        check("rst_mem_address", 64'(mem_address), 64'(0));
        check("rst_mem_write_data", 64'(mem_write_data), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Single request: channel 0 reads address 5 (holds 0x2A)
        set_ch(0, 2'b00, 5);
        expect_tx(0, 2'b00, 5);
        req = 3'b001;
        @(negedge clk);
        check("single_exec_early", 64'(mem_execute), 64'(0));
        @(negedge clk);
        check("single_exec_latency", 64'(mem_execute), 64'(1));
        check("single_addr", 64'(mem_address), 64'(5));
        wait_done(0, 20, "single_done_timeout");
        check("single_done", 64'(done), 64'(3'b001));
        check("single_rd_data", 64'(rd_data), 64'(32'h2A));
        req = '0;
        @(negedge clk);
        check("single_done_pulse", 64'(done), 64'(0));
        check("single_rd_hold", 64'(rd_data), 64'(32'h2A));

        // Fresh reset so channel 0 wins first again
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Contention: all three channels request continuously for 6 transactions
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 2'(c), 10 + c);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++) expect_tx(c, 2'(c), 10 + c);
        req = 3'b111;
        n = 0;
        for (int i = 0; i < 300 && n < 6; i++) begin
            @(negedge clk);
            if (done != '0) n++;
        end
        req = '0;
        check("contention_count", 64'(n), 64'(6));
        repeat (2) @(negedge clk);

        // Slow memory: is_ready held low 10 cycles
        lat = 10;
        set_ch(1, 2'b01, 20);
        expect_tx(1, 2'b01, 20);
        req = 3'b010;
        wait_exec(20, "slow_exec_timeout");
        for (int i = 0; i < 40 && !is_done(1); i++) begin
            @(negedge clk);
            check("slow_grant_stable", 64'(grant), 64'(3'b010));
            check("slow_addr_stable", 64'(mem_address), 64'(20));
        end
        check("slow_done", 64'(is_done(1)), 64'(1));
        req = '0;
        lat = 1;
        repeat (2) @(negedge clk);

        // Lock: channel 1 runs three transactions, channel 0 competes
`ifdef ARB_LOCK_EN
        expect_tx(1, 2'b00, 30);
        expect_tx(1, 2'b00, 31);
        expect_tx(1, 2'b00, 32);
        expect_tx(0, 2'b00, 33);
        expect_tx(0, 2'b00, 34);
`else
        expect_tx(1, 2'b00, 30);
        expect_tx(0, 2'b00, 33);
        expect_tx(1, 2'b00, 31);
        expect_tx(0, 2'b00, 34);
        expect_tx(1, 2'b00, 32);
`endif
        set_ch(1, 2'b00, 30);
        req_lock = 3'b010;
        req      = 3'b010;
        wait_exec(20, "lock_exec_timeout");
        set_ch(0, 2'b00, 33);
        req[0] = 1'b1;
        n0 = 0;
        n1 = 0;
        unlock = 1'b0;
        for (int i = 0; i < 400 && !(n0 == 2 && n1 == 3); i++) begin
            @(negedge clk);
            if (unlock) begin
                req_lock[1] = 1'b0;
                unlock = 1'b0;
            end
            if (done[1]) begin
                n1++;
                if (n1 == 1) set_ch(1, 2'b00, 31);
                else if (n1 == 2) begin
                    set_ch(1, 2'b00, 32);
                    unlock = 1'b1;
                end else req[1] = 1'b0;
            end
            if (done[0]) begin
                n0++;
                if (n0 == 1) set_ch(0, 2'b00, 34);
                else req[0] = 1'b0;
            end
        end
        check("lock_ch1_count", 64'(n1), 64'(3));
        check("lock_ch0_count", 64'(n0), 64'(2));
        req      = '0;
        req_lock = '0;
        repeat (2) @(negedge clk);

        // Reset in the middle of BUSY
        lat = 10;
        set_ch(1, 2'b00, 40);
        expect_tx(1, 2'b00, 40);
        req = 3'b010;
        wait_exec(20, "rstbusy_exec_timeout");
        set_ch(0, 2'b00, 41);
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstbusy_grant", 64'(grant), 64'(0));
        check("rstbusy_exec", 64'(mem_execute), 64'(0));
        check("rstbusy_done", 64'(done), 64'(0));
        check("rstbusy_addr", 64'(mem_address), 64'(0));
        sb.delete();
        expect_tx(0, 2'b00, 41);
        expect_tx(1, 2'b00, 40);
        lat = 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 2; i++) begin
            @(negedge clk);
            if (done[0]) begin
                req[0] = 1'b0;
                n++;
            end
            if (done[1]) begin
                req[1] = 1'b0;
                n++;
            end
        end
        check("rstbusy_count", 64'(n), 64'(2));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
